// File: rtl/bp_me_wormhole_stream_encode_pkg.sv
// bp_me_wormhole_stream_encode_pkg: shared FSM states and flit-count helper for the wormhole stream codec
package bp_me_wormhole_stream_encode_pkg;
  typedef enum logic [1:0] {e_idle, e_hdr, e_data} wh_state_e;
  function automatic int cdiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/bp_me_wormhole_len_calc.sv
// bp_me_wormhole_len_calc: per-message data flit count and wormhole len field
module bp_me_wormhole_len_calc
  import bp_me_wormhole_stream_encode_pkg::*;
#(
  parameter int flit_width_p = 64,
  parameter int hdr_flits_p  = 2,
  parameter int len_width_p  = 5,
  parameter int size_width_p = 3,
  parameter int cnt_width_p  = 6
) (
  input  logic                    has_data_i,
  input  logic [size_width_p-1:0] size_i,
  output logic [cnt_width_p-1:0]  data_flits_o,
  output logic [len_width_p-1:0]  len_o,
  output logic                    len_ok_o
);
  int full_len;
  assign data_flits_o = has_data_i ? cnt_width_p'(cdiv(8 << size_i, flit_width_p)) : '0;
  assign full_len = hdr_flits_p + int'(data_flits_o) - 1;
  assign len_o = len_width_p'(full_len);
  assign len_ok_o = full_len < (1 << len_width_p);
endmodule

// File: rtl/bp_me_wormhole_stream_encode.sv
// bp_me_wormhole_stream_encode: serialises a BedRock header plus data stream into wormhole flits
module bp_me_wormhole_stream_encode
  import bp_me_wormhole_stream_encode_pkg::*;
#(
  parameter int flit_width_p    = 64,
  parameter int cord_width_p    = 8,
  parameter int len_width_p     = 5,
  parameter int cid_width_p     = 2,
  parameter int msg_hdr_width_p = 86,
  parameter int data_width_p    = 128,
  parameter int size_width_p    = 3
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [msg_hdr_width_p-1:0] in_header_i,
  input  logic [cord_width_p-1:0]    in_cord_i,
  input  logic [cid_width_p-1:0]     in_cid_i,
  input  logic                       in_has_data_i,
  input  logic [size_width_p-1:0]    in_size_i,
  input  logic [data_width_p-1:0]    in_data_i,
  input  logic                       in_v_i,
  input  logic                       in_last_i,
  output logic                       in_ready_and_o,
  output logic [flit_width_p-1:0]    link_data_o,
  output logic                       link_v_o,
  input  logic                       link_ready_and_i
);
  localparam int hdr_bits   = cord_width_p + len_width_p + cid_width_p + msg_hdr_width_p;
  localparam int hdr_flits  = cdiv(hdr_bits, flit_width_p);
  localparam int hdr_w      = hdr_flits * flit_width_p;
  localparam int beat_flits = data_width_p / flit_width_p;
  localparam int cw         = len_width_p + 1;

  wh_state_e state, state_n;
  logic [cw-1:0] hdr_cnt, beat_cnt, rem_cnt, data_flits;
  logic [len_width_p-1:0] len, len_r;
  logic len_ok, hs, last_hdr, beat_done;
  logic [hdr_w-1:0] hdr_vec;
  logic [flit_width_p-1:0] hdr_flit, data_flit;

  bp_me_wormhole_len_calc #(
    .flit_width_p(flit_width_p),
    .hdr_flits_p (hdr_flits),
    .len_width_p (len_width_p),
    .size_width_p(size_width_p),
    .cnt_width_p (cw)
  ) len_calc (
    .has_data_i  (in_has_data_i),
    .size_i      (in_size_i),
    .data_flits_o(data_flits),
    .len_o       (len),
    .len_ok_o    (len_ok)
  );

  // {pad, msg_hdr, cid, len, cord}, zero padded at the MSB
  assign hdr_vec = hdr_w'({in_header_i, in_cid_i, len_r, in_cord_i});

  always_comb begin
    hdr_flit = '0;
    data_flit = '0;
    for (int i = 0; i < hdr_flits; i++)
      if (hdr_cnt == cw'(i)) hdr_flit = hdr_vec[i*flit_width_p +: flit_width_p];
    for (int i = 0; i < beat_flits; i++)
      if (beat_cnt == cw'(i)) data_flit = in_data_i[i*flit_width_p +: flit_width_p];
  end

  assign link_v_o    = (state == e_hdr) | ((state == e_data) & in_v_i);
  assign link_data_o = (state == e_data) ? data_flit : hdr_flit;
  assign hs          = link_v_o & link_ready_and_i;
  assign last_hdr    = hdr_cnt == cw'(hdr_flits - 1);
  // a beat retires on its last flit or on the final flit of a partial tail beat
  assign beat_done   = hs & (state == e_data) & ((beat_cnt == cw'(beat_flits - 1)) | (rem_cnt == cw'(1)));

  always_comb begin
    state_n = state;
    in_ready_and_o = 1'b0;
    if (state == e_idle) state_n = in_v_i ? e_hdr : e_idle;
    else if (state == e_hdr) begin
      in_ready_and_o = hs & last_hdr & ~in_has_data_i;
      if (hs & last_hdr) state_n = in_has_data_i ? e_data : e_idle;
    end else begin
      in_ready_and_o = beat_done;
      if (hs & (rem_cnt == cw'(1))) state_n = e_idle;
    end
  end

  always_ff @(posedge clk_i)
    if (reset_i) begin
      state <= e_idle;
      hdr_cnt <= '0;
      beat_cnt <= '0;
      rem_cnt <= '0;
      len_r <= '0;
    end else begin
      state <= state_n;
      if (state == e_idle) begin
        hdr_cnt <= '0;
        beat_cnt <= '0;
        rem_cnt <= data_flits;
        len_r <= len;
      end else if (hs && state == e_hdr) hdr_cnt <= hdr_cnt + 1'b1;
      else if (hs) begin
        beat_cnt <= beat_done ? '0 : beat_cnt + 1'b1;
        rem_cnt <= rem_cnt - 1'b1;
      end
    end

  always_ff @(posedge clk_i)
    if (!reset_i) begin
      if (state == e_idle && in_v_i) assert (len_ok);
      if (beat_done) assert (in_last_i == (rem_cnt == cw'(1)));
    end
endmodule

// File: tb/tb_bp_me_wormhole_stream_encode.sv
// tb_bp_me_wormhole_stream_encode: directed flit-order, back-pressure, reset and bubble checks
module tb_bp_me_wormhole_stream_encode;
  logic clk_i = 1'b0, reset_i;
  logic [85:0] in_header_i;
  logic [7:0] in_cord_i;
  logic [1:0] in_cid_i;
  logic in_has_data_i, in_v_i, in_last_i, in_ready_and_o, link_v_o, link_ready_and_i;
  logic [2:0] in_size_i;
  logic [127:0] in_data_i;
  logic [63:0] link_data_o;
  int checks = 0, failures = 0;

  always #5 clk_i = ~clk_i;

  bp_me_wormhole_stream_encode dut (
    .clk_i(clk_i), .reset_i(reset_i), .in_header_i(in_header_i), .in_cord_i(in_cord_i),
    .in_cid_i(in_cid_i), .in_has_data_i(in_has_data_i), .in_size_i(in_size_i),
    .in_data_i(in_data_i), .in_v_i(in_v_i), .in_last_i(in_last_i),
    .in_ready_and_o(in_ready_and_o), .link_data_o(link_data_o), .link_v_o(link_v_o),
    .link_ready_and_i(link_ready_and_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] beat(input logic [7:0] s, input int i);
    return {s, 24'(i), 32'hC0DE_0000 | 32'(i), s, 24'hABCDEF ^ 24'(i), 32'h1234_5678 + 32'(i)};
  endfunction

  // drives one message with in_v_i held high; rst_at aborts with a reset when flit rst_at is on the link
  task automatic send(input logic [85:0] hdr, input logic [7:0] cord, input logic [1:0] cid,
                      input logic hd, input logic [2:0] sz, input logic [4:0] exp_len,
                      input int ndata, input int nbeats, input logic [7:0] seed,
                      input bit stall, input int rst_at);
    logic [127:0] hv, b;
    logic [63:0] exp_f;
    int k = 0, bi = 0, bubbles = 0, cyc = 0;
    int nfl = 2 + ndata;
    bit cons;
    hv = {27'b0, hdr, cid, exp_len, cord};
    while (k < nfl && cyc < 200) begin
      in_header_i = hdr; in_cord_i = cord; in_cid_i = cid; in_has_data_i = hd; in_size_i = sz;
      in_v_i = 1'b1; in_data_i = beat(seed, bi); in_last_i = (bi == nbeats - 1);
      link_ready_and_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k == rst_at) begin
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        return;
      end
      @(negedge clk_i);
      if (k < 2) exp_f = (k == 0) ? hv[63:0] : hv[127:64];
      else begin
        b = beat(seed, (k - 2) / 2);
        exp_f = ((k - 2) % 2 == 1) ? b[127:64] : b[63:0];
      end
      cons = hd ? (k >= 2 && (((k - 2) % 2 == 1) || (k - 2 == ndata - 1))) : (k == 1);
      if (!link_v_o) begin
        if (k == 0) bubbles++;
        else chk("link_v_mid_packet", 64'(link_v_o), 64'(1));
        chk("ready_while_idle", 64'(in_ready_and_o), 64'(0));
      end else begin
        chk($sformatf("flit%0d_data", k), link_data_o, exp_f);
        if (link_ready_and_i) begin
          chk($sformatf("flit%0d_ready", k), 64'(in_ready_and_o), 64'(cons));
          k++;
          if (cons) bi++;
        end else chk("ready_during_stall", 64'(in_ready_and_o), 64'(0));
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    chk("flits_sent", 64'(k), 64'(nfl));
    chk("beats_consumed", 64'(bi), 64'(nbeats));
    chk("bubbles", 64'(bubbles), 64'(1));
  endtask

  initial begin
    reset_i = 1'b1; in_v_i = 1'b1; in_last_i = 1'b0; link_ready_and_i = 1'b1;
    in_header_i = '0; in_cord_i = '0; in_cid_i = '0; in_has_data_i = 1'b0; in_size_i = '0; in_data_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_link_v", 64'(link_v_o), 64'(0));
    chk("reset_ready", 64'(in_ready_and_o), 64'(0));
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    // no data: len 1, ready pulses with header flit 2
    send(86'h2A_5555_AAAA_1234_5678_9ABC, 8'h3C, 2'd2, 1'b0, 3'd0, 5'd1, 0, 1, 8'h11, 1'b0, -1);
    // 64B: len 9, 8 data flits, 4 beats
    send(86'h15_0F0F_F0F0_DEAD_BEEF_CAFE, 8'hA5, 2'd1, 1'b1, 3'd6, 5'd9, 8, 4, 8'h22, 1'b0, -1);
    // 1B: len 2, single data flit from the low half
    send(86'h3F_FFFF_0000_0000_FFFF_0001, 8'h01, 2'd3, 1'b1, 3'd0, 5'd2, 1, 1, 8'h33, 1'b0, -1);
    // 128B with random link stalls: len 17, 18 flits
    send(86'h01_2345_6789_ABCD_EF01_2345, 8'h7E, 2'd0, 1'b1, 3'd7, 5'd17, 16, 8, 8'h44, 1'b1, -1);
    // 32B: two full beats
    send(86'h00_0000_0000_0000_0000_00FF, 8'h80, 2'd2, 1'b1, 3'd5, 5'd5, 4, 2, 8'h55, 1'b1, -1);
    // 64B aborted by reset on its third data flit
    send(86'h0A_AAAA_BBBB_CCCC_DDDD_EEEE, 8'h42, 2'd1, 1'b1, 3'd6, 5'd9, 8, 4, 8'h66, 1'b0, 4);
    send(86'h0B_1111_2222_3333_4444_5555, 8'h24, 2'd3, 1'b1, 3'd6, 5'd9, 8, 4, 8'h77, 1'b0, -1);
    // back-to-back mix, 8B (one flit) and no-data
    send(86'h1C_9999_8888_7777_6666_5555, 8'hFF, 2'd0, 1'b1, 3'd3, 5'd2, 1, 1, 8'h88, 1'b0, -1);
    send(86'h2D_1212_3434_5656_7878_9090, 8'h00, 2'd1, 1'b0, 3'd7, 5'd1, 0, 1, 8'h99, 1'b1, -1);
    send(86'h3E_ABAB_CDCD_EFEF_0101_2323, 8'h5A, 2'd2, 1'b1, 3'd6, 5'd9, 8, 4, 8'hAA, 1'b1, -1);
    in_v_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      chk("idle_link_v", 64'(link_v_o), 64'(0));
      chk("idle_ready", 64'(in_ready_and_o), 64'(0));
      @(posedge clk_i); #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
